// File: rtl/mips_multiciclo_ctrl_if.sv
// Control bundle between the multi-cycle MIPS main controller and its datapath.
// master: the controller side; slave: the datapath side.
interface mips_multiciclo_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_err;
    logic [3:0] estado;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
               illegal_op, mem_err, estado
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
               illegal_op, mem_err, estado
    );
endinterface

// File: rtl/mips_multiciclo_ctrl.sv
// Moore main-control FSM for the multi-cycle MIPS datapath, with memory-wait timeout.
// Define CTRL_ADDI_EN to build the addi path (ADDIEX/ADDIWB); otherwise addi is illegal.
module mips_multiciclo_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic                    clock,
    input logic                    reset_n,
    mips_multiciclo_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9
`ifdef CTRL_ADDI_EN
        ,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11
`endif
    } state_e;

    localparam logic [7:0] CntLast = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       waiting;
    logic       timeout;

    assign bus.estado = state_q;
    assign waiting = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign timeout = waiting && !bus.mem_ready && (cnt_q == CntLast);

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.instr_done    = 1'b0;
        bus.illegal_op    = 1'b0;
        bus.mem_err       = 1'b0;
        state_d           = state_q;
        cnt_d             = 8'd0;

        // While in reset only the fetch request is visible; every enable stays low.
        if (!reset_n) begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'b01;
            state_d       = StFetch;
        end else begin
            case (state_q)
                StFetch: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = StDecode;
                    end
                end
                StDecode: begin
                    bus.alu_src_b = 2'b11;
                    case (bus.opcode)
                        6'b100011, 6'b101011: state_d = StMemAdr;
                        6'b000000:            state_d = StExec;
                        6'b000100:            state_d = StBranch;
                        6'b000010:            state_d = StJump;
`ifdef CTRL_ADDI_EN
                        6'b001000:            state_d = StAddiEx;
`endif
                        default: begin
                            bus.illegal_op = 1'b1;
                            state_d        = StFetch;
                        end
                    endcase
                end
                StMemAdr: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    state_d       = (bus.opcode == 6'b100011) ? StMemRd : StMemWr;
                end
                StMemRd: begin
                    bus.i_or_d   = 1'b1;
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) state_d = StMemWb;
                end
                StMemWb: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    bus.instr_done = 1'b1;
                    state_d        = StFetch;
                end
                StMemWr: begin
                    bus.i_or_d     = 1'b1;
                    bus.mem_write  = 1'b1;
                    bus.instr_done = bus.mem_ready;
                    if (bus.mem_ready) state_d = StFetch;
                end
                StExec: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b10;
                    state_d       = StAluWb;
                end
                StAluWb: begin
                    bus.reg_dst    = 1'b1;
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                    state_d        = StFetch;
                end
                StBranch: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = 2'b01;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 2'b01;
                    bus.instr_done    = 1'b1;
                    state_d           = StFetch;
                end
                StJump: begin
                    bus.pc_write   = 1'b1;
                    bus.pc_source  = 2'b10;
                    bus.instr_done = 1'b1;
                    state_d        = StFetch;
                end
`ifdef CTRL_ADDI_EN
                StAddiEx: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    state_d       = StAddiWb;
                end
                StAddiWb: begin
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                    state_d        = StFetch;
                end
`endif
                default: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    state_d       = StFetch;
                end
            endcase

            // Timeout only fires when mem_ready is low, so no enable above was raised.
            if (timeout) begin
                bus.mem_err = 1'b1;
                state_d     = StFetch;
            end else if (waiting && !bus.mem_ready) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mips_multiciclo_ctrl.sv
// Directed bench for mips_multiciclo_ctrl: per-cycle expected control words go through a
// scoreboard queue and are compared on the falling edge.
module tb_mips_multiciclo_ctrl;
    localparam int unsigned TO = 15;

    logic clock;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    logic [22:0] exp_q[$];

    mips_multiciclo_ctrl_if bus ();

    mips_multiciclo_ctrl #(
        .MEM_TIMEOUT(TO)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Reference control word for a state, following the control table of the datapath.
    function automatic logic [22:0] model(input logic [3:0] st, input logic rdy,
                                          input logic merr, input logic ill, input logic rst);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, done;
        logic [1:0] srcb, aop, psrc;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, done} = '0;
        {srcb, aop, psrc} = '0;
        case (st)
            4'd0: begin mr = 1; srcb = 2'b01; irw = rdy & ~rst; pcw = rdy & ~rst; end
            4'd1: srcb = 2'b11;
            4'd2: begin srca = 1; srcb = 2'b10; end
            4'd3: begin iord = 1; mr = 1; end
            4'd4: begin rw = 1; m2r = 1; done = 1; end
            4'd5: begin iord = 1; mw = 1; done = rdy; end
            4'd6: begin srca = 1; aop = 2'b10; end
            4'd7: begin rdst = 1; rw = 1; done = 1; end
            4'd8: begin srca = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; done = 1; end
            4'd9: begin pcw = 1; psrc = 2'b10; done = 1; end
            4'd10: begin srca = 1; srcb = 2'b10; end
            4'd11: begin rw = 1; done = 1; end
            default: begin mr = 1; srcb = 2'b01; end
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, aop, psrc,
                done, ill, merr, st};
    endfunction

    function automatic logic [22:0] observe();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done, bus.illegal_op,
                bus.mem_err, bus.estado};
    endfunction

    task automatic cyc(input logic rn, input logic [5:0] op, input logic rdy,
                       input logic [22:0] expv, input string tag);
        logic [22:0] e;
        logic [22:0] got;
        reset_n       = rn;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        exp_q.push_back(expv);
        @(negedge clock);
        e   = exp_q.pop_front();
        got = observe();
        total++;
        assert (got === e)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, e);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b1;

        cyc(0, 6'h00, 1, model(4'd0, 1, 0, 0, 1), "reset");
        cyc(0, 6'h00, 1, model(4'd0, 1, 0, 0, 1), "reset_hold");

        // R-type
        cyc(1, 6'h00, 1, model(4'd0, 1, 0, 0, 0), "r_fetch");
        cyc(1, 6'h00, 1, model(4'd1, 1, 0, 0, 0), "r_decode");
        cyc(1, 6'h00, 1, model(4'd6, 1, 0, 0, 0), "r_exec");
        cyc(1, 6'h00, 1, model(4'd7, 1, 0, 0, 0), "r_aluwb");

        // Reset asserted while in EXEC
        cyc(1, 6'h00, 1, model(4'd0, 1, 0, 0, 0), "rr_fetch");
        cyc(1, 6'h00, 1, model(4'd1, 1, 0, 0, 0), "rr_decode");
        cyc(0, 6'h00, 1, model(4'd0, 1, 0, 0, 1), "rst_in_exec");
        cyc(1, 6'h00, 1, model(4'd0, 1, 0, 0, 0), "rel_fetch");
        cyc(1, 6'h00, 1, model(4'd1, 1, 0, 0, 0), "rel_decode");
        cyc(1, 6'h00, 1, model(4'd6, 1, 0, 0, 0), "rel_exec");
        cyc(1, 6'h00, 1, model(4'd7, 1, 0, 0, 0), "rel_aluwb");

        // lw with three wait cycles
        cyc(1, 6'h23, 1, model(4'd0, 1, 0, 0, 0), "lw_fetch");
        cyc(1, 6'h23, 1, model(4'd1, 1, 0, 0, 0), "lw_decode");
        cyc(1, 6'h23, 1, model(4'd2, 1, 0, 0, 0), "lw_memadr");
        for (int i = 0; i < 3; i++) cyc(1, 6'h23, 0, model(4'd3, 0, 0, 0, 0), "lw_memrd_wait");
        cyc(1, 6'h23, 1, model(4'd3, 1, 0, 0, 0), "lw_memrd_ready");
        cyc(1, 6'h23, 1, model(4'd4, 1, 0, 0, 0), "lw_memwb");

        // sw with memory stuck: timeout on the TO-th MEMWR cycle
        cyc(1, 6'h2B, 1, model(4'd0, 1, 0, 0, 0), "sw_fetch");
        cyc(1, 6'h2B, 1, model(4'd1, 1, 0, 0, 0), "sw_decode");
        cyc(1, 6'h2B, 1, model(4'd2, 1, 0, 0, 0), "sw_memadr");
        for (int i = 0; i < int'(TO) - 1; i++)
            cyc(1, 6'h2B, 0, model(4'd5, 0, 0, 0, 0), "sw_memwr_wait");
        cyc(1, 6'h2B, 0, model(4'd5, 0, 1, 0, 0), "sw_timeout");

        // beq
        cyc(1, 6'h04, 1, model(4'd0, 1, 0, 0, 0), "beq_fetch");
        cyc(1, 6'h04, 1, model(4'd1, 1, 0, 0, 0), "beq_decode");
        cyc(1, 6'h04, 1, model(4'd8, 1, 0, 0, 0), "beq_branch");

        // Unsupported opcode
        cyc(1, 6'h3F, 1, model(4'd0, 1, 0, 0, 0), "ill_fetch");
        cyc(1, 6'h3F, 1, model(4'd1, 1, 0, 1, 0), "ill_decode");

        // j
        cyc(1, 6'h02, 1, model(4'd0, 1, 0, 0, 0), "j_fetch");
        cyc(1, 6'h02, 1, model(4'd1, 1, 0, 0, 0), "j_decode");
        cyc(1, 6'h02, 1, model(4'd9, 1, 0, 0, 0), "j_jump");

        // addi
        cyc(1, 6'h08, 1, model(4'd0, 1, 0, 0, 0), "addi_fetch");
`ifdef CTRL_ADDI_EN
        cyc(1, 6'h08, 1, model(4'd1, 1, 0, 0, 0), "addi_decode");
        cyc(1, 6'h08, 1, model(4'd10, 1, 0, 0, 0), "addi_ex");
        cyc(1, 6'h08, 1, model(4'd11, 1, 0, 0, 0), "addi_wb");
`else
        cyc(1, 6'h08, 1, model(4'd1, 1, 0, 1, 0), "addi_illegal");
`endif

        // Timeout while fetching stays in FETCH
        for (int i = 0; i < int'(TO) - 1; i++)
            cyc(1, 6'h00, 0, model(4'd0, 0, 0, 0, 0), "fetch_wait");
        cyc(1, 6'h00, 0, model(4'd0, 0, 1, 0, 0), "fetch_timeout");
        cyc(1, 6'h00, 0, model(4'd0, 0, 0, 0, 0), "fetch_after_to");
        cyc(1, 6'h23, 1, model(4'd0, 1, 0, 0, 0), "fetch_ready");

        // lw where mem_ready arrives exactly on the timeout cycle: ready wins
        cyc(1, 6'h23, 1, model(4'd1, 1, 0, 0, 0), "lwb_decode");
        cyc(1, 6'h23, 1, model(4'd2, 1, 0, 0, 0), "lwb_memadr");
        for (int i = 0; i < int'(TO) - 1; i++)
            cyc(1, 6'h23, 0, model(4'd3, 0, 0, 0, 0), "lwb_memrd_wait");
        cyc(1, 6'h23, 1, model(4'd3, 1, 0, 0, 0), "lwb_ready_at_limit");
        cyc(1, 6'h23, 1, model(4'd4, 1, 0, 0, 0), "lwb_memwb");
        cyc(1, 6'h00, 1, model(4'd0, 1, 0, 0, 0), "final_fetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_multiciclo_ctrl.md
Name: mips_multiciclo_ctrl

Overview:
- Moore-style main control FSM for the multi-cycle MIPS datapath.
- Sequences fetch/decode/execute/memory/writeback.
- Drives the 2-bit ALUOp consumed by the ALU control decoder (00 add, 01 sub, 10 funct-decoded), plus all mux selects and write enables.
- Stalls on a memory-ready handshake, with timeout recovery.

Parameters:
MEM_TIMEOUT, 15, max consecutive wait cycles with mem_ready=0 before abort (1..255); counter width 8 bits.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
opcode  in  6  instruction opcode from IR; stable from DECODE through instruction end
mem_ready  in  1  memory access complete this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
mem_to_reg  out  1  register write-data select: 1 MDR
reg_dst  out  1  destination select: 1 rd, 0 rt
reg_write  out  1  register file write
alu_src_a  out  1  0 PC, 1 A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
alu_op  out  2  to ALU control
pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
instr_done  out  1  last cycle of a completed instruction
illegal_op  out  1  one-cycle pulse, unsupported opcode
mem_err  out  1  one-cycle pulse, memory timeout
estado  out  4  current state code, debug

Behaviour:
- Outputs decode combinationally from the state register. Exceptions: outputs qualified by mem_ready/opcode as noted below.
- Every output not listed for a state is 0.
- Reset (async, reset_n=0): state=FETCH(0), wait counter=0.
- Outputs during reset: mem_read=1, alu_src_b=01, all others 0, estado=0.
- State codes and actions:
  - FETCH(0): mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=1 only in cycle mem_ready=1. Next: DECODE on mem_ready.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00. Next by opcode:
    - 100011 / 101011 -> MEMADR
    - 000000 -> EXEC
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDIEX (see optional feature)
    - other -> FETCH with illegal_op=1 this cycle
  - MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD if opcode=100011, else MEMWR.
  - MEMRD(3): i_or_d=1, mem_read=1. Next: MEMWB on mem_ready.
  - MEMWB(4): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next: FETCH.
  - MEMWR(5): i_or_d=1, mem_write=1; instr_done=mem_ready. Next: FETCH on mem_ready.
  - EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
  - ALUWB(7): reg_dst=1, reg_write=1, instr_done=1. Next: FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next: FETCH.
  - JUMP(9): pc_write=1, pc_source=10, instr_done=1. Next: FETCH.
  - ADDIEX(10): alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
  - ADDIWB(11): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next: FETCH.
- Wait counter (FETCH, MEMRD, MEMWR only):
  - Increments each cycle mem_ready=0; clears on any state change or mem_ready=1.
  - When counter=MEM_TIMEOUT-1 and mem_ready=0: mem_err=1 that cycle, next state FETCH, counter cleared. No enables (ir_write/pc_write/instr_done) assert on a timeout cycle.
  - Simultaneous mem_ready=1 and timeout: mem_ready wins, no mem_err.
- Unused codes 12-15: next state FETCH, outputs as reset.
- Reset asserted mid-instruction: immediate return to FETCH; no write enable asserted after reset_n falls.
- Latencies with zero-wait memory: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.

Optional Feature:
CTRL_ADDI_EN:
- Defined: opcode 001000 follows DECODE->ADDIEX->ADDIWB->FETCH.
- Undefined: states 10/11 not built; 001000 treated as illegal (illegal_op pulse, return to FETCH).

Test Plan:
- reset_n low while in EXEC -> estado=0, mem_read=1, alu_src_b=01, reg_write=0 immediately; release, mem_ready=1 -> DECODE next cycle.
- R-type (opcode 000000), mem_ready always 1 -> estado 0,1,6,7,0; alu_op=10 in EXEC; reg_write=1 and reg_dst=1 only in ALUWB; instr_done one cycle.
- lw (100011), mem_ready low 3 cycles in MEMRD -> remains state 3 for 4 cycles, then 4 with mem_to_reg=1 and reg_write=1; total 8 cycles.
- sw (101011), mem_ready stuck 0, MEM_TIMEOUT=15 -> mem_err pulses on 15th MEMWR cycle, next estado=0, mem_write never coincides with instr_done.
- beq (000100) -> state 8 with alu_op=01, pc_write_cond=1, pc_source=01; opcode 111111 -> illegal_op one cycle in DECODE, back to FETCH.
- addi (001000) -> with CTRL_ADDI_EN: estado 0,1,10,11,0, reg_write in 11 with reg_dst=0; without: illegal_op=1 in DECODE.
